// File: rtl/regfile_mp_bypass_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Module-level widths are derived from the instance parameters via reg_idx_w().
package riscv_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_IDX_W = $clog2(NREGS_DEF);
  localparam int REG_ZERO  = 0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0]  xlen_t;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  function automatic int reg_idx_w(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_wport_arb.sv
// Resolves the enabled write ports into at most one winner per register.
// The highest-index port targeting a register wins; x0 writes never win.
module regfile_wport_arb
  import riscv_rf_pkg::*;
#(
  parameter int NWRITE = 1,
  parameter int IW     = 5
) (
  input  logic [NWRITE-1:0]    en,
  input  logic [NWRITE*IW-1:0] sel,
  output logic [NWRITE-1:0]    win,
  output logic                 collision
);

  always_comb begin
    win       = '0;
    collision = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      win[j] = en[j] && (sel[j*IW +: IW] != IW'(REG_ZERO));
      // A later port on the same register overrides this one.
      for (int k = j + 1; k < NWRITE; k++) begin
        if (en[k] && (sel[k*IW +: IW] == sel[j*IW +: IW])) begin
          if (win[j]) collision = 1'b1;
          win[j] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with write-to-read bypass, x0 hardwired to zero,
// and a post-reset sequencer that clears one register per cycle.
module regfile_mp_bypass
  import riscv_rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREAD*reg_idx_w(NREGS)-1:0]    readRegSel,
  output logic [NREAD*XLEN-1:0]                readData,
  input  logic [NWRITE*reg_idx_w(NREGS)-1:0]   writeRegSel,
  input  logic [NWRITE*XLEN-1:0]               writeData,
  input  logic [NWRITE-1:0]                    writeEn,
  output logic                                 ready,
  output logic                                 err,
  output logic                                 dbg_state
);

  localparam int IW = reg_idx_w(NREGS);

  rf_state_t         state, state_next;
  logic [IW-1:0]     clr_idx, clr_idx_next;
  logic              clear_we;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NWRITE-1:0] wen_gated;
  logic [NWRITE-1:0] win;
  logic              collision;

  // ready is a level, not a per-write handshake: every writeEn sampled on an
  // edge with ready high is committed, and nothing is acknowledged per write.
  assign ready     = (state == RF_RUN);
  assign dbg_state = (state == RF_RUN);
  assign wen_gated = ready ? writeEn : '0;

  regfile_wport_arb #(
    .NWRITE (NWRITE),
    .IW     (IW)
  ) u_arb (
    .en        (wen_gated),
    .sel       (writeRegSel),
    .win       (win),
    .collision (collision)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= IW'(1);
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      err     <= collision;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    clear_we     = 1'b0;
    case (state)
      RF_CLEAR: begin
        clear_we     = 1'b1;
        clr_idx_next = clr_idx + 1'b1;
        if (clr_idx == IW'(NREGS - 1)) state_next = RF_RUN;
      end
      RF_RUN:  state_next = RF_RUN;
      default: state_next = RF_CLEAR;
    endcase
  end

  // Storage carries no reset so it can map onto plain flop or latch banks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) regs[clr_idx] <= '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (win[j]) regs[writeRegSel[j*IW +: IW]] <= writeData[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    logic [IW-1:0] rsel;
    readData = '0;
    for (int i = 0; i < NREAD; i++) begin
      rsel = readRegSel[i*IW +: IW];
      if (ready && (rsel != IW'(REG_ZERO))) begin
        readData[i*XLEN +: XLEN] = regs[rsel];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWRITE; j++) begin
            if (win[j] && (writeRegSel[j*IW +: IW] == rsel))
              readData[i*XLEN +: XLEN] = writeData[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Bench for regfile_mp_bypass: a 2-write bypassing instance and a 1-write
// non-bypassing instance share clock, reset and read selects.
module tb_regfile_mp_bypass;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rsel = '0;
  logic [9:0]  wsel = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  we = '0;
  logic [63:0] rd_a, rd_b;
  logic        ready_a, ready_b, err_a, err_b, dbg_a, dbg_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents plus remaining clear cycles.
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  int          clr_left = 31;
  logic        err_exp_a = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_mp_bypass #(
    .XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .readRegSel  (rsel),
    .readData    (rd_a),
    .writeRegSel (wsel),
    .writeData   (wdata),
    .writeEn     (we),
    .ready       (ready_a),
    .err         (err_a),
    .dbg_state   (dbg_a)
  );

  regfile_mp_bypass #(
    .XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(1), .BYPASS(0)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .readRegSel  (rsel),
    .readData    (rd_b),
    .writeRegSel (wsel[4:0]),
    .writeData   (wdata[31:0]),
    .writeEn     (we[0:0]),
    .ready       (ready_b),
    .err         (err_b),
    .dbg_state   (dbg_b)
  );

  function automatic logic [31:0] exp_rd(input bit is_a, input int port);
    logic [4:0] s;
    s = rsel[port*5 +: 5];
    if (clr_left != 0 || s == 5'd0) return 32'd0;
    if (is_a) begin
      if (we[1] && wsel[9:5] == s) return wdata[63:32];
      if (we[0] && wsel[4:0] == s) return wdata[31:0];
      return mem_a[s];
    end
    return mem_b[s];
  endfunction

  task automatic drive(input logic r, input logic [1:0] e,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    rst   = r;
    we    = e;
    wsel  = {s1, s0};
    wdata = {d1, d0};
    rsel  = {r1, r0};
    #1;
  endtask

  // Advance one edge and update the model from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clr_left  = 31;
      err_exp_a = 1'b0;
    end else if (clr_left > 0) begin
      clr_left  = clr_left - 1;
      err_exp_a = 1'b0;
      if (clr_left == 0) begin
        for (int r = 0; r < 32; r++) begin
          mem_a[r] = '0;
          mem_b[r] = '0;
        end
      end
    end else begin
      err_exp_a = we[0] && we[1] && (wsel[4:0] == wsel[9:5]) && (wsel[4:0] != 5'd0);
      if (we[0] && wsel[4:0] != 5'd0) begin
        mem_a[wsel[4:0]] = wdata[31:0];
        mem_b[wsel[4:0]] = wdata[31:0];
      end
      if (we[1] && wsel[9:5] != 5'd0) mem_a[wsel[9:5]] = wdata[63:32];
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({ready_a, ready_b, err_a, err_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state got=%b want=0000", {ready_a, ready_b, err_a, err_b});
    end
    for (int c = 1; c <= 32; c++) begin
      drive(1'b0, 2'b00, 0, 0, 0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      vectors++;
      if (ready_a !== (c == 32) || ready_b !== (c == 32)) begin
        miscompares++;
        $display("FAIL reset_ready cycle=%0d got=%b%b want=%b", c, ready_a, ready_b, (c == 32));
      end
      vectors++;
      if (c < 32 && (rd_a !== 64'd0 || rd_b !== 64'd0)) begin
        miscompares++;
        $display("FAIL clear_read cycle=%0d got=%h/%h want=0", c, rd_a, rd_b);
      end
      tick();
      vectors++;
      if (err_a !== 1'b0 || err_b !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_err cycle=%0d got=%b%b want=00", c, err_a, err_b);
      end
    end
    for (int r = 0; r < 32; r++) begin
      drive(1'b0, 2'b00, 0, 0, 0, 0, 5'(r), 5'(31 - r));
      vectors++;
      if (rd_a !== 64'd0 || rd_b !== 64'd0) begin
        miscompares++;
        $display("FAIL cleared_reg x%0d got=%h/%h want=0", r, rd_a, rd_b);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 5);
    vectors++;
    if (rd_a !== {2{32'hDEADBEEF}}) begin
      miscompares++;
      $display("FAIL bypass_same got=%h want=%h", rd_a, {2{32'hDEADBEEF}});
    end
    vectors++;
    if (rd_b[31:0] !== 32'd0) begin
      miscompares++;
      $display("FAIL nobypass_same got=%h want=0", rd_b[31:0]);
    end
    tick();
    drive(1'b0, 2'b00, 0, 0, 0, 0, 5, 5);
    vectors++;
    if (rd_a[31:0] !== 32'hDEADBEEF || rd_b[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_next got=%h/%h want=deadbeef", rd_a[31:0], rd_b[31:0]);
    end
    tick();
  endtask

  task automatic test_x0();
    drive(1'b0, 2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    vectors++;
    if (rd_a !== 64'd0 || rd_b !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_same got=%h/%h want=0", rd_a, rd_b);
    end
    tick();
    vectors++;
    if (err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_err got=%b want=0", err_a);
    end
    drive(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (rd_a !== 64'd0 || rd_b !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_next got=%h/%h want=0", rd_a, rd_b);
    end
    tick();
  endtask

  task automatic test_collision();
    drive(1'b0, 2'b11, 7, 7, 32'h11, 32'h22, 7, 7);
    vectors++;
    if (rd_a !== {2{32'h22}}) begin
      miscompares++;
      $display("FAIL collide_bypass got=%h want=%h", rd_a, {2{32'h22}});
    end
    tick();
    vectors++;
    if (err_a !== 1'b1 || err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_err got=%b%b want=10", err_a, err_b);
    end
    drive(1'b0, 2'b00, 0, 0, 0, 0, 7, 7);
    vectors++;
    if (rd_a[31:0] !== 32'h22 || rd_b[31:0] !== 32'h11) begin
      miscompares++;
      $display("FAIL collide_stored got=%h/%h want=22/11", rd_a[31:0], rd_b[31:0]);
    end
    tick();
    vectors++;
    if (err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_err_pulse got=%b want=0", err_a);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int c = 0; c < 300; c++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
      for (int p = 0; p < 2; p++) begin
        exp_q.push_back(exp_rd(1'b1, p));
        exp_q.push_back(exp_rd(1'b0, p));
      end
      for (int p = 0; p < 2; p++) begin
        got = rd_a[p*32 +: 32];
        vectors++;
        if (got !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rand_rd_a c=%0d p=%0d got=%h want=%h", c, p, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got = rd_b[p*32 +: 32];
        vectors++;
        if (got !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rand_rd_b c=%0d p=%0d got=%h want=%h", c, p, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      vectors++;
      if (err_a !== err_exp_a || err_b !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_err c=%0d got=%b%b want=%b0", c, err_a, err_b, err_exp_a);
      end
    end
  endtask

  task automatic test_clear_write();
    drive(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 1; c <= 31; c++) begin
      if (c == 5) drive(1'b0, 2'b01, 3, 0, 32'h55, 0, 3, 3);
      else        drive(1'b0, 2'b00, 0, 0, 0, 0, 3, 3);
      vectors++;
      if (rd_a !== 64'd0 || rd_b !== 64'd0 || ready_a !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_write_rd cycle=%0d got=%h/%h rdy=%b want=0", c, rd_a, rd_b, ready_a);
      end
      tick();
    end
    drive(1'b0, 2'b00, 0, 0, 0, 0, 3, 3);
    vectors++;
    if (ready_a !== 1'b1 || rd_a !== 64'd0 || rd_b !== 64'd0) begin
      miscompares++;
      $display("FAIL clear_write_after rdy=%b got=%h/%h want=1,0", ready_a, rd_a, rd_b);
    end
    tick();
  endtask

  task automatic test_mid_clear_reset();
    drive(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 1; c <= 32; c++) begin
      drive(1'b0, 2'b00, 0, 0, 0, 0, 9, 1);
      vectors++;
      if (ready_a !== (c == 32) || ready_b !== (c == 32) || dbg_b !== (c == 32)) begin
        miscompares++;
        $display("FAIL midclear_ready cycle=%0d got=%b%b%b want=%b", c, ready_a, ready_b, dbg_b, (c == 32));
      end
      if (c < 32) tick();
    end
    tick();
  endtask

  task automatic test_nobypass();
    drive(1'b0, 2'b01, 9, 0, 32'hA5, 0, 9, 9);
    vectors++;
    if (rd_b[31:0] !== 32'd0 || rd_a[31:0] !== 32'hA5) begin
      miscompares++;
      $display("FAIL nobypass_same got=%h/%h want=a5/0", rd_a[31:0], rd_b[31:0]);
    end
    tick();
    drive(1'b0, 2'b00, 0, 0, 0, 0, 9, 9);
    vectors++;
    if (rd_b !== {2{32'hA5}}) begin
      miscompares++;
      $display("FAIL nobypass_next got=%h want=%h", rd_b, {2{32'hA5}});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_collision();
    test_random();
    test_clear_write();
    test_mid_clear_reset();
    test_nobypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
